td4x_core: RTL and testbench

//  Parametrised next-generation TD4 CPU core: A/B registers, carry flag, PC, output latch, TD4 opcode set.

---
 rtl/td4x_pkg.sv | 33 +++
 rtl/td4x_prog_mem.sv | 39 +++
 rtl/td4x_core.sv | 133 +++++++++++++
 tb/tb_td4x_core.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4x_pkg.sv
// Shared TD4X definitions: opcodes, FSM states, instruction packer and the default ROM image.
package td4x_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  function automatic logic [7:0] instr(input logic [3:0] op, input logic [3:0] im);
    return {op, im};
  endfunction

  // Ramen timer, word 0 in the low byte: blink 7/6/0-4 through counting loops, show 8, halt at 15.
  localparam logic [15:0][7:0] DEFAULT_PROG = {
    8'hFF, 8'hB8, 8'hEA, 8'h01, 8'hB4, 8'hB0, 8'hE8, 8'h01,
    8'hE6, 8'h01, 8'hB6, 8'hE3, 8'h01, 8'hE1, 8'h01, 8'hB7
  };

endpackage

// File: rtl/td4x_prog_mem.sv
// Program store: async read; writable RAM when TD4X_PROG_EN is defined, else a ROM of DEFAULT_PROG.
module td4x_prog_mem
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
`ifdef TD4X_PROG_EN
  input  logic              clk,
  input  logic              we,
  input  logic [PC_W-1:0]   waddr,
  input  logic [DATA_W+3:0] wdata,
`endif
  input  logic [PC_W-1:0]   raddr,
  output logic [DATA_W+3:0] rdata
);

  localparam int DEPTH = 2 ** PC_W;

`ifdef TD4X_PROG_EN
  logic [DATA_W+3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
`else
  // The 4-bit image is widened by zero-extending the immediate; words past 15 read as ADD A,0.
  function automatic logic [DATA_W+3:0] rom_word(input logic [PC_W-1:0] a);
    logic [7:0] w;
    w = (32'(a) < 32'd16) ? DEFAULT_PROG[4'(a)] : 8'h00;
    return {w[7:4], DATA_W'(w[3:0])};
  endfunction

  assign rdata = rom_word(raddr);
`endif

endmodule

// File: rtl/td4x_core.sv
// TD4X CPU core: run/step/clear FSM, decode, ALU, A/B/C/PC/output registers and halt detect.
// Build option TD4X_PROG_EN adds the prog_* write port; otherwise the program is a fixed ROM.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              clr,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              halted,
  output logic [PC_W-1:0]   pc_o,
  output logic              carry_o,
`ifdef TD4X_PROG_EN
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W+3:0] prog_data,
`endif
  output logic [1:0]        dbg_state
);

  state_t            state;
  logic [DATA_W-1:0] a_reg, b_reg, out_reg;
  logic              c_reg;
  logic [PC_W-1:0]   pc;

  logic [DATA_W+3:0] instr_w;
  logic [3:0]        op;
  logic [DATA_W-1:0] im;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;
  logic              wr_a, wr_b, wr_out, jump, valid, exec;
  logic [PC_W-1:0]   target, pc_next;
  logic              halt_hit;

`ifdef TD4X_PROG_EN
  logic mem_we;
  assign mem_we = prog_we && (state != RUN);
`endif

  td4x_prog_mem #(.DATA_W(DATA_W), .PC_W(PC_W)) u_mem (
`ifdef TD4X_PROG_EN
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
`endif
    .raddr (pc),
    .rdata (instr_w)
  );

  assign op = instr_w[DATA_W+3:DATA_W];
  assign im = instr_w[DATA_W-1:0];

  always_comb begin
    exec = 1'b0;
    case (state)
      IDLE:    exec = run | step;
      RUN:     exec = run;
      default: exec = 1'b0;
    endcase
  end

  always_comb begin
    src    = '0;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    wr_out = 1'b0;
    jump   = 1'b0;
    valid  = 1'b1;
    case (op)
      OP_ADD_A:  begin src = a_reg;   wr_a = 1'b1; end
      OP_MOV_AB: begin src = b_reg;   wr_a = 1'b1; end
      OP_IN_A:   begin src = in_port; wr_a = 1'b1; end
      OP_MOV_A:  wr_a = 1'b1;
      OP_MOV_BA: begin src = a_reg;   wr_b = 1'b1; end
      OP_ADD_B:  begin src = b_reg;   wr_b = 1'b1; end
      OP_IN_B:   begin src = in_port; wr_b = 1'b1; end
      OP_MOV_B:  wr_b = 1'b1;
      OP_OUT_B:  begin src = b_reg;   wr_out = 1'b1; end
      OP_OUT_IM: wr_out = 1'b1;
      OP_JNC:    jump = ~c_reg;
      OP_JMP:    jump = 1'b1;
      default:   valid = 1'b0;
    endcase
  end

  // Jumps add im to zero, so they always clear C, as on the original TD4.
  assign sum      = {1'b0, src} + {1'b0, im};
  assign target   = im[PC_W-1:0];
  assign pc_next  = jump ? target : pc + PC_W'(1);
  assign halt_hit = jump && (target == pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      c_reg   <= 1'b0;
      pc      <= '0;
    end else if (clr) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      c_reg   <= 1'b0;
      pc      <= '0;
    end else if (exec) begin
      c_reg <= valid ? sum[DATA_W] : 1'b0;
      pc    <= pc_next;
      if (wr_a)   a_reg   <= sum[DATA_W-1:0];
      if (wr_b)   b_reg   <= sum[DATA_W-1:0];
      if (wr_out) out_reg <= sum[DATA_W-1:0];
      if (halt_hit)                  state <= HALTED;
      else if (state == IDLE && run) state <= RUN;
    end else if (state == RUN) begin
      state <= IDLE;
    end
  end

  assign out_port  = out_reg;
  assign pc_o      = pc;
  assign carry_o   = c_reg;
  assign halted    = (state == HALTED);
  assign dbg_state = state;

endmodule

// File: tb/tb_td4x_core.sv
// Directed bench for td4x_core: narrow (4/4) and wide (8/6) instances; program-load or ROM flavour.
module tb_td4x_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0, step = 1'b0, clr = 1'b0;
  logic [3:0] in_port = 4'h0;
  logic [3:0] out_port;
  logic       halted;
  logic [3:0] pc_o;
  logic       carry_o;
  logic [1:0] dbg_state;

  logic       w_run = 1'b0, w_step = 1'b0, w_clr = 1'b0;
  logic [7:0] w_in = 8'h00;
  logic [7:0] w_out;
  logic       w_halted;
  logic [5:0] w_pc;
  logic       w_carry;
  logic [1:0] w_state;

`ifdef TD4X_PROG_EN
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'h0;
  logic [7:0]  prog_data = 8'h00;
  logic        w_prog_we = 1'b0;
  logic [5:0]  w_prog_addr = 6'h00;
  logic [11:0] w_prog_data = 12'h000;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  td4x_core #(.DATA_W(4), .PC_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .clr       (clr),
    .in_port   (in_port),
    .out_port  (out_port),
    .halted    (halted),
    .pc_o      (pc_o),
    .carry_o   (carry_o),
`ifdef TD4X_PROG_EN
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
`endif
    .dbg_state (dbg_state)
  );

  td4x_core #(.DATA_W(8), .PC_W(6)) u_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (w_run),
    .step      (w_step),
    .clr       (w_clr),
    .in_port   (w_in),
    .out_port  (w_out),
    .halted    (w_halted),
    .pc_o      (w_pc),
    .carry_o   (w_carry),
`ifdef TD4X_PROG_EN
    .prog_we   (w_prog_we),
    .prog_addr (w_prog_addr),
    .prog_data (w_prog_data),
`endif
    .dbg_state (w_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

`ifdef TD4X_PROG_EN
  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    cyc(1);
    prog_we   = 1'b0;
  endtask

  task automatic w_load(input logic [5:0] a, input logic [11:0] d);
    w_prog_addr = a;
    w_prog_data = d;
    w_prog_we   = 1'b1;
    cyc(1);
    w_prog_we   = 1'b0;
  endtask

  task automatic load_t1();
    load(4'd0, 8'h33);
    load(4'd1, 8'h05);
    load(4'd2, 8'h40);
    load(4'd3, 8'h90);
    load(4'd4, 8'hF4);
  endtask
`endif

  initial begin
    cyc(2);
    check("rst_out", out_port, 4'h0);
    check("rst_pc", pc_o, 4'h0);
    check("rst_carry", carry_o, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_w_pc", w_pc, 6'd0);
    rst_n = 1'b1;
    cyc(1);

`ifdef TD4X_PROG_EN
    // T1: MOV A,3; ADD A,5; MOV B,A; OUT B; JMP 4
    load_t1();
    run = 1'b1;
    cyc(4);
    check("t1_out", out_port, 4'h8);
    check("t1_pc", pc_o, 4'd4);
    check("t1_not_halted", halted, 1'b0);
    check("t1_state_run", dbg_state, 2'd1);
    cyc(1);
    check("t1_halted", halted, 1'b1);
    check("t1_halt_pc", pc_o, 4'd4);
    check("t1_state_halted", dbg_state, 2'd2);
    pulse_step();
    check("halt_hold_pc", pc_o, 4'd4);
    check("halt_hold", halted, 1'b1);
    run = 1'b0;

    // T4: write in HALTED together with clr, then an attempted write while running
    prog_addr = 4'd3;
    prog_data = 8'hB9;
    prog_we   = 1'b1;
    clr       = 1'b1;
    cyc(1);
    prog_we = 1'b0;
    clr     = 1'b0;
    check("t4_clr_pc", pc_o, 4'd0);
    check("t4_clr_halted", halted, 1'b0);
    check("t4_clr_out", out_port, 4'h0);
    check("t4_clr_state", dbg_state, 2'd0);
    run = 1'b1;
    cyc(1);
    prog_addr = 4'd3;
    prog_data = 8'hB5;
    prog_we   = 1'b1;
    cyc(1);
    prog_we = 1'b0;
    cyc(2);
    check("t4_halted_write_kept", out_port, 4'h9);
    cyc(1);
    check("t4_halted_again", halted, 1'b1);
    run = 1'b0;

    // T2: MOV A,F; ADD A,1; JNC 0; OUT 9; JMP 4
    pulse_clr();
    load(4'd0, 8'h3F);
    load(4'd1, 8'h01);
    load(4'd2, 8'hE0);
    load(4'd3, 8'hB9);
    load(4'd4, 8'hF4);
    run = 1'b1;
    cyc(2);
    check("t2_carry_set", carry_o, 1'b1);
    check("t2_pc2", pc_o, 4'd2);
    cyc(1);
    check("t2_jnc_not_taken", pc_o, 4'd3);
    check("t2_jnc_clears_c", carry_o, 1'b0);
    cyc(1);
    check("t2_out", out_port, 4'h9);
    cyc(1);
    check("t2_halted", halted, 1'b1);
    run = 1'b0;

    // IN B; OUT B+2; JMP 2
    pulse_clr();
    load(4'd0, 8'h60);
    load(4'd1, 8'h92);
    load(4'd2, 8'hF2);
    in_port = 4'h6;
    run = 1'b1;
    cyc(2);
    check("in_out_sum", out_port, 4'h8);
    check("in_out_carry", carry_o, 1'b0);
    cyc(1);
    check("in_halted_pc", pc_o, 4'd2);
    run = 1'b0;
    pulse_clr();
    in_port = 4'hE;
    run = 1'b1;
    cyc(2);
    check("in_wrap_out", out_port, 4'h0);
    check("in_wrap_carry", carry_o, 1'b1);
    cyc(1);
    run = 1'b0;

    // T3: single steps on the T1 program
    pulse_clr();
    load_t1();
    for (int i = 1; i <= 3; i++) begin
      pulse_step();
      check("t3_step_pc", pc_o, 32'(i));
      check("t3_step_idle", dbg_state, 2'd0);
    end
    cyc(2);
    check("t3_idle_hold", pc_o, 4'd3);

    // T5: asynchronous reset mid-run, memory retained
    pulse_clr();
    run = 1'b1;
    cyc(4);
    check("t5_pre_out", out_port, 4'h8);
    rst_n = 1'b0;
    #2;
    check("t5_async_out", out_port, 4'h0);
    check("t5_async_pc", pc_o, 4'd0);
    check("t5_async_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    cyc(4);
    check("t5_rerun_out", out_port, 4'h8);
    cyc(1);
    check("t5_rerun_halted", halted, 1'b1);
    run = 1'b0;

    // T6: wide core, OUT 5A; MOV A,FF; ADD A,1; MOV B,A; OUT B; JMP 3F; (3F) JMP 3F
    w_load(6'd0, 12'hB5A);
    w_load(6'd1, 12'h3FF);
    w_load(6'd2, 12'h001);
    w_load(6'd3, 12'h400);
    w_load(6'd4, 12'h900);
    w_load(6'd5, 12'hF3F);
    w_load(6'd63, 12'hF3F);
    w_run = 1'b1;
    cyc(1);
    check("t6_out_im", w_out, 8'h5A);
    cyc(2);
    check("t6_carry", w_carry, 1'b1);
    check("t6_pc3", w_pc, 6'd3);
    cyc(2);
    check("t6_a_wrapped", w_out, 8'h00);
    check("t6_carry_cleared", w_carry, 1'b0);
    cyc(1);
    check("t6_jmp_3f", w_pc, 6'd63);
    check("t6_not_halted", w_halted, 1'b0);
    cyc(1);
    check("t6_halted", w_halted, 1'b1);
    check("t6_halt_pc", w_pc, 6'd63);
    w_run = 1'b0;
`else
    // Steps through the ramen-timer ROM: OUT 7; ADD A,1; JNC 1
    pulse_step();
    check("step1_pc", pc_o, 4'd1);
    check("step1_out", out_port, 4'h7);
    check("step1_idle", dbg_state, 2'd0);
    pulse_step();
    check("step2_pc", pc_o, 4'd2);
    pulse_step();
    check("step3_jnc_taken", pc_o, 4'd1);
    run = 1'b1;
    cyc(1);
    check("run_pc", pc_o, 4'd2);
    check("run_state", dbg_state, 2'd1);
    cyc(1);
    run = 1'b0;
    cyc(1);
    check("stop_pc", pc_o, 4'd1);
    check("stop_state", dbg_state, 2'd0);

    // clr wins over an instruction in the same cycle
    run = 1'b1;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("clr_pc", pc_o, 4'd0);
    check("clr_out", out_port, 4'h0);
    check("clr_state", dbg_state, 2'd0);

    // Full run from clean state, run still high
    cyc(1);
    check("rom_e1_out", out_port, 4'h7);
    cyc(31);
    check("rom_e32_carry", carry_o, 1'b1);
    check("rom_e32_pc", pc_o, 4'd2);
    cyc(1);
    check("rom_e33_pc", pc_o, 4'd3);
    check("rom_e33_carry", carry_o, 1'b0);
    cyc(33);
    check("rom_e66_out", out_port, 4'h6);
    check("rom_e66_pc", pc_o, 4'd6);
    cyc(65);
    check("rom_e131_out", out_port, 4'h0);
    check("rom_e131_pc", pc_o, 4'd11);
    cyc(1);
    check("rom_e132_out", out_port, 4'h4);
    cyc(63);
    check("rom_e195_out", out_port, 4'h8);
    check("rom_e195_pc", pc_o, 4'd15);
    check("rom_e195_not_halted", halted, 1'b0);
    cyc(1);
    check("rom_halted", halted, 1'b1);
    check("rom_halt_pc", pc_o, 4'd15);
    check("rom_halt_state", dbg_state, 2'd2);
    pulse_step();
    cyc(2);
    check("halt_hold_pc", pc_o, 4'd15);
    check("halt_hold_out", out_port, 4'h8);
    check("halt_hold", halted, 1'b1);
    run = 1'b0;
    pulse_clr();
    check("halt_clr", halted, 1'b0);
    check("halt_clr_pc", pc_o, 4'd0);

    // Asynchronous reset mid-run
    run = 1'b1;
    cyc(4);
    check("mid_pc", pc_o, 4'd2);
    check("mid_out", out_port, 4'h7);
    rst_n = 1'b0;
    #2;
    check("async_out", out_port, 4'h0);
    check("async_pc", pc_o, 4'd0);
    check("async_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    cyc(1);
    check("rerun_out", out_port, 4'h7);
    check("rerun_pc", pc_o, 4'd1);
    run = 1'b0;

    // Wide core: the first counting loop needs 256 ADDs before carry
    w_run = 1'b1;
    cyc(1);
    check("w_e1_out", w_out, 8'h07);
    check("w_e1_pc", w_pc, 6'd1);
    cyc(510);
    check("w_e511_carry", w_carry, 1'b0);
    cyc(1);
    check("w_e512_carry", w_carry, 1'b1);
    check("w_e512_pc", w_pc, 6'd2);
    cyc(1);
    check("w_e513_pc", w_pc, 6'd3);
    w_run = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
